mux_word_serializer: RTL and testbench



---
 rtl/mux_word_serializer.sv | 120 ++++++++++++
 tb/tb_mux_word_serializer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_word_serializer.sv
// ============================================================================
// Module  : mux_word_serializer
// Brief   : Loads a 16-bit word onto an external 16:1 mux, walks its select
//           and emits the selected bits serially with an optional parity beat.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module mux_word_serializer #(
  parameter int unsigned HOLD      = 1,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [0:15] load_data,
  output logic [0:15] mux_in,
  output logic [0:3]  mux_sel,
  input  logic        mux_out,
  output logic        ser_valid,
  output logic        ser_data,
  output logic        ser_last,
  output logic        busy
);

  localparam int unsigned     CW        = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CW-1:0]   C_CNT_MAX = CW'(HOLD - 1);
  localparam logic [0:3]      C_SEL_MAX = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_acc;
  logic [0:15]   r_mux_in;
  logic [0:3]    r_mux_sel;
  logic          r_ser_valid;
  logic          r_ser_data;
  logic          r_ser_last;
  logic          w_capture;

  assign w_capture = (r_cnt == C_CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_acc       <= 1'b0;
      r_mux_in    <= '0;
      r_mux_sel   <= '0;
      r_ser_valid <= 1'b0;
      r_ser_data  <= 1'b0;
      r_ser_last  <= 1'b0;
    end else begin
      r_ser_valid <= 1'b0;
      r_ser_last  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_mux_sel <= '0;
          if (load_valid) begin
            r_mux_in <= load_data;
            r_cnt    <= '0;
            r_acc    <= 1'b0;
            r_state  <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_capture) begin
            // mux_out reflects the select presented this cycle; no extra stage
            r_ser_data  <= mux_out;
            r_ser_valid <= 1'b1;
            r_acc       <= r_acc ^ mux_out;
            r_cnt       <= '0;
            if (r_mux_sel != C_SEL_MAX) begin
              r_mux_sel <= r_mux_sel + 4'd1;
            end else if (PARITY_EN) begin
              r_state <= ST_PARITY;
            end else begin
              r_state    <= ST_IDLE;
              r_mux_sel  <= '0;
              r_ser_last <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_PARITY: begin
          if (w_capture) begin
            r_ser_data  <= r_acc;
            r_ser_valid <= 1'b1;
            r_ser_last  <= 1'b1;
            r_cnt       <= '0;
            r_mux_sel   <= '0;
            r_state     <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Handshake status decodes straight from the state so reset shows at once
  assign load_ready = (r_state == ST_IDLE);
  assign busy       = (r_state != ST_IDLE);
  assign mux_in     = r_mux_in;
  assign mux_sel    = r_mux_sel;
  assign ser_valid  = r_ser_valid;
  assign ser_data   = r_ser_data;
  assign ser_last   = r_ser_last;

endmodule

`default_nettype wire

// File: tb/tb_mux_word_serializer.sv
// ============================================================================
// Module  : tb_mux_word_serializer
// Brief   : Directed, table-driven bench for mux_word_serializer with three
//           parameter sets and a behavioural 16:1 mux in the loop.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mux_word_serializer;

  logic        clk;
  logic        rst_n;
  logic        lv [3];
  logic [0:15] ld [3];
  logic        lr [3];
  logic [0:15] mi [3];
  logic [0:3]  ms [3];
  logic        mo [3];
  logic        sv [3];
  logic        sd [3];
  logic        sl [3];
  logic        bz [3];

  int checks = 0;
  int errors = 0;

  // Behavioural model of the downstream 16:1 mux
  assign mo[0] = mi[0][ms[0]];
  assign mo[1] = mi[1][ms[1]];
  assign mo[2] = mi[2][ms[2]];

  mux_word_serializer #(.HOLD(1), .PARITY_EN(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[0]), .load_ready(lr[0]),
    .load_data(ld[0]), .mux_in(mi[0]), .mux_sel(ms[0]), .mux_out(mo[0]),
    .ser_valid(sv[0]), .ser_data(sd[0]), .ser_last(sl[0]), .busy(bz[0]));

  mux_word_serializer #(.HOLD(1), .PARITY_EN(1'b0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[1]), .load_ready(lr[1]),
    .load_data(ld[1]), .mux_in(mi[1]), .mux_sel(ms[1]), .mux_out(mo[1]),
    .ser_valid(sv[1]), .ser_data(sd[1]), .ser_last(sl[1]), .busy(bz[1]));

  mux_word_serializer #(.HOLD(3), .PARITY_EN(1'b1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .load_valid(lv[2]), .load_ready(lr[2]),
    .load_data(ld[2]), .mux_in(mi[2]), .mux_sel(ms[2]), .mux_out(mo[2]),
    .ser_valid(sv[2]), .ser_data(sd[2]), .ser_last(sl[2]), .busy(bz[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic [0:15] word;
    logic [0:16] bits;
    int          nbeats;
    int          hold;
  } vec_t;

  localparam int NV = 5;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  int d, n, h, b, exp_sel;

  initial begin
    vecs[0] = '{d: 0, word: 16'h8000, bits: 17'b1000_0000_0000_0000_1, nbeats: 17, hold: 1};
    vecs[1] = '{d: 1, word: 16'hA5A5, bits: 17'b1010_0101_1010_0101_0, nbeats: 16, hold: 1};
    vecs[2] = '{d: 2, word: 16'h8001, bits: 17'b1000_0000_0000_0001_0, nbeats: 17, hold: 3};
    vecs[3] = '{d: 0, word: 16'h7FFF, bits: 17'b0111_1111_1111_1111_1, nbeats: 17, hold: 1};
    vecs[4] = '{d: 1, word: 16'h3C01, bits: 17'b0011_1100_0000_0001_0, nbeats: 16, hold: 1};

    for (int i = 0; i < 3; i++) begin
      lv[i] = 1'b0;
      ld[i] = '0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_lr%0d", i), lr[i], 1);
      chk($sformatf("rst_busy%0d", i), bz[i], 0);
      chk($sformatf("rst_sv%0d", i), sv[i], 0);
      chk($sformatf("rst_sl%0d", i), sl[i], 0);
      chk($sformatf("rst_sd%0d", i), sd[i], 0);
      chk($sformatf("rst_mi%0d", i), mi[i], 0);
      chk($sformatf("rst_ms%0d", i), ms[i], 0);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Table-driven single-word runs
    for (int v = 0; v < NV; v++) begin
      d = vecs[v].d;
      n = vecs[v].nbeats;
      h = vecs[v].hold;
      chk($sformatf("v%0d_idle_lr", v), lr[d], 1);
      lv[d] = 1'b1;
      ld[d] = vecs[v].word;
      tick();
      lv[d] = 1'b0;
      ld[d] = ~vecs[v].word;
      chk($sformatf("v%0d_acc_busy", v), bz[d], 1);
      chk($sformatf("v%0d_acc_lr", v), lr[d], 0);
      chk($sformatf("v%0d_acc_mi", v), mi[d], vecs[v].word);
      chk($sformatf("v%0d_acc_ms", v), ms[d], 0);
      for (int c = 1; c <= n * h; c++) begin
        tick();
        if (c % h == 0) begin
          b = c / h - 1;
          chk($sformatf("v%0d_c%0d_sv", v, c), sv[d], 1);
          chk($sformatf("v%0d_b%0d_sd", v, b), sd[d], vecs[v].bits[b]);
          chk($sformatf("v%0d_b%0d_sl", v, b), sl[d], (b == n - 1) ? 1 : 0);
        end else begin
          chk($sformatf("v%0d_c%0d_sv_lo", v, c), sv[d], 0);
          chk($sformatf("v%0d_c%0d_sl_lo", v, c), sl[d], 0);
        end
        exp_sel = (c == n * h) ? 0 : ((c / h > 15) ? 15 : c / h);
        chk($sformatf("v%0d_c%0d_ms", v, c), ms[d], exp_sel);
      end
      chk($sformatf("v%0d_end_lr", v), lr[d], 1);
      chk($sformatf("v%0d_end_busy", v), bz[d], 0);
      tick();
      chk($sformatf("v%0d_post_sv", v), sv[d], 0);
      chk($sformatf("v%0d_post_sl", v), sl[d], 0);
      chk($sformatf("v%0d_post_sd_hold", v), sd[d], vecs[v].bits[n-1]);
      chk($sformatf("v%0d_post_mi_keep", v), mi[d], vecs[v].word);
      ld[d] = '0;
    end

    // Back-to-back: load_valid held high across two words
    lv[0] = 1'b1;
    ld[0] = 16'hFFFF;
    tick();
    ld[0] = 16'h0001;
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk($sformatf("b2b_w0_c%0d_sv", c), sv[0], 1);
      chk($sformatf("b2b_w0_c%0d_sd", c), sd[0], (c == 17) ? 0 : 1);
      chk($sformatf("b2b_w0_c%0d_sl", c), sl[0], (c == 17) ? 1 : 0);
      if (c == 5) chk("b2b_w0_mi_locked", mi[0], 16'hFFFF);
    end
    chk("b2b_lr_at_last", lr[0], 1);
    tick();
    chk("b2b_gap_sv", sv[0], 0);
    chk("b2b_w1_busy", bz[0], 1);
    chk("b2b_w1_mi", mi[0], 16'h0001);
    for (int c = 1; c <= 17; c++) begin
      tick();
      if (c == 1) lv[0] = 1'b0;
      chk($sformatf("b2b_w1_c%0d_sv", c), sv[0], 1);
      chk($sformatf("b2b_w1_c%0d_sd", c), sd[0], (c >= 16) ? 1 : 0);
      chk($sformatf("b2b_w1_c%0d_sl", c), sl[0], (c == 17) ? 1 : 0);
    end
    tick();
    chk("b2b_done_busy", bz[0], 0);

    // Reset in the middle of a word
    lv[0] = 1'b1;
    ld[0] = 16'hFFFF;
    tick();
    lv[0] = 1'b0;
    for (int c = 1; c <= 5; c++) tick();
    chk("rmw_beat5_sv", sv[0], 1);
    chk("rmw_beat5_sd", sd[0], 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rmw_lr", lr[0], 1);
    chk("rmw_busy", bz[0], 0);
    chk("rmw_sv", sv[0], 0);
    chk("rmw_sd", sd[0], 0);
    chk("rmw_sl", sl[0], 0);
    chk("rmw_mi", mi[0], 0);
    chk("rmw_ms", ms[0], 0);
    tick();
    chk("rmw_hold1_sl", sl[0], 0);
    tick();
    chk("rmw_hold2_sl", sl[0], 0);
    rst_n = 1'b1;
    tick();
    chk("rmw_after_sv", sv[0], 0);
    chk("rmw_after_sl", sl[0], 0);
    lv[0] = 1'b1;
    ld[0] = 16'h8000;
    tick();
    lv[0] = 1'b0;
    tick();
    chk("rmw_new_sv", sv[0], 1);
    chk("rmw_new_sd", sd[0], 1);
    chk("rmw_new_ms", ms[0], 1);
    for (int c = 2; c <= 17; c++) tick();
    chk("rmw_new_last", sl[0], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
